// File: rtl/cvxif_coproc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cvxif_coproc_pkg
// Description : Coprocessor-private types: slot state enum, slot record,
//               default parameter values and the issue predecoder.
// Revision    : 1.0 - initial release
// ============================================================================
package cvxif_coproc_pkg;

    localparam int unsigned c_default_nr_slots  = 4;
    localparam int unsigned c_default_xlen      = 64;
    localparam int unsigned c_default_lat_mode  = 0;
    localparam int unsigned c_default_fixed_lat = 2;
    localparam int unsigned c_default_result_rd = 17;

    localparam int unsigned c_cnt_w          = 4;
    localparam logic [6:0]  c_opcode_custom3 = 7'b1111011;

    typedef enum logic [1:0] {
        SLOT_FREE      = 2'd0,
        SLOT_ISSUED    = 2'd1,
        SLOT_COMMITTED = 2'd2,
        SLOT_KILLED    = 2'd3
    } slot_state_e;

    typedef struct packed {
        logic [cvxif_pkg::c_x_id_width-1:0]   id;
        logic [cvxif_pkg::c_x_data_width-1:0] sum;
        slot_state_e                          state;
        logic [c_cnt_w-1:0]                   cnt;
    } slot_t;

    // Only the custom-3 major opcode is claimed; no register writeback.
    function automatic cvxif_pkg::x_issue_resp_t predecode(input logic [6:0] opcode);
        cvxif_pkg::x_issue_resp_t r;
        r           = '0;
        r.accept    = (opcode == c_opcode_custom3);
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cvxif_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cvxif_pkg
// Description : Core <-> coprocessor X-interface channel types. The request
//               carries the compressed, issue, commit, mem and result-ready
//               channels. The response carries everything returned to the core.
// Revision    : 1.0 - initial release
// ============================================================================
package cvxif_pkg;

    localparam int unsigned c_x_id_width   = 4;
    localparam int unsigned c_x_data_width = 64;
    localparam int unsigned c_x_num_rs     = 3;

    typedef struct packed {
        logic [15:0] instr;
    } x_compressed_req_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        accept;
    } x_compressed_resp_t;

    typedef struct packed {
        logic [31:0]                                 instr;
        logic [c_x_id_width-1:0]                     id;
        logic [c_x_num_rs-1:0][c_x_data_width-1:0]   rs;
    } x_issue_req_t;

    typedef struct packed {
        logic accept;
        logic writeback;
        logic loadstore;
        logic exc;
    } x_issue_resp_t;

    typedef struct packed {
        logic [c_x_id_width-1:0] id;
        logic                    commit_kill;
    } x_commit_t;

    typedef struct packed {
        logic [c_x_id_width-1:0] id;
        logic [31:0]             addr;
        logic                    we;
    } x_mem_req_t;

    typedef struct packed {
        logic [c_x_id_width-1:0]   id;
        logic [c_x_data_width-1:0] data;
        logic [4:0]                rd;
        logic                      we;
        logic                      exc;
        logic [5:0]                exccode;
    } x_result_t;

    typedef struct packed {
        logic              x_compressed_valid;
        x_compressed_req_t x_compressed_req;
        logic              x_issue_valid;
        x_issue_req_t      x_issue_req;
        logic              x_commit_valid;
        x_commit_t         x_commit;
        logic              x_mem_ready;
        logic              x_result_ready;
    } cvxif_req_t;

    typedef struct packed {
        logic               x_compressed_ready;
        x_compressed_resp_t x_compressed_resp;
        logic               x_issue_ready;
        x_issue_resp_t      x_issue_resp;
        logic               x_mem_valid;
        x_mem_req_t         x_mem_req;
        logic               x_result_valid;
        x_result_t          x_result;
    } cvxif_resp_t;

endpackage
`default_nettype wire

// File: rtl/cvxif_coproc_slot.sv
`default_nettype none
// ============================================================================
// Module      : cvxif_coproc_slot
// Description : One outstanding-instruction slot with its lifecycle FSM
//               FREE -> ISSUED -> COMMITTED/KILLED -> FREE.
//               Ports: clk_i/rst_i, write_i + id_i/sum_i (allocate),
//               commit_valid_i/commit_id_i/commit_kill_i (commit channel),
//               free_i (release by head logic), slot_o (registered slot).
// Revision    : 1.0 - initial release
// ============================================================================
module cvxif_coproc_slot
    import cvxif_pkg::*, cvxif_coproc_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      write_i,
    input  logic [c_x_id_width-1:0]   id_i,
    input  logic [c_x_data_width-1:0] sum_i,
    input  logic                      commit_valid_i,
    input  logic [c_x_id_width-1:0]   commit_id_i,
    input  logic                      commit_kill_i,
    input  logic                      free_i,
    output slot_t                     slot_o
);

    slot_t r_slot_q;
    slot_t w_slot_d;

    always_comb begin
        w_slot_d = r_slot_q;
        case (r_slot_q.state)
            SLOT_FREE: begin
                if (write_i) begin
                    w_slot_d.id    = id_i;
                    w_slot_d.sum   = sum_i;
                    w_slot_d.cnt   = '0;
                    w_slot_d.state = SLOT_ISSUED;
                end
            end
            SLOT_ISSUED: begin
                // Only ISSUED slots match a commit, so a same-cycle write to
                // a FREE slot can never collide with a commit.
                if (commit_valid_i && (commit_id_i == r_slot_q.id)) begin
                    w_slot_d.cnt   = '0;
                    w_slot_d.state = commit_kill_i ? SLOT_KILLED : SLOT_COMMITTED;
                end
            end
            SLOT_COMMITTED: begin
                if (r_slot_q.cnt != {c_cnt_w{1'b1}}) begin
                    w_slot_d.cnt = r_slot_q.cnt + c_cnt_w'(1);
                end
                if (free_i) begin
                    w_slot_d.state = SLOT_FREE;
                end
            end
            SLOT_KILLED: begin
                if (free_i) begin
                    w_slot_d.state = SLOT_FREE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_slot_q <= '0;
        end else begin
            r_slot_q <= w_slot_d;
        end
    end

    assign slot_o = r_slot_q;

endmodule
`default_nettype wire

// File: rtl/cvxif_multi_slot_coprocessor.sv
`default_nettype none
// ============================================================================
// Module      : cvxif_multi_slot_coprocessor
// Description : CV-X-IF coprocessor holding up to NrSlots outstanding
//               instructions in a circular buffer. Each accepted issue stores
//               rs[0]+rs[1]+rs[2]; results return in issue order once the head
//               slot is committed and its latency has elapsed.
//               Ports: clk_i (rising edge), rst_i (sync, active-high),
//               cvxif_req_i (core -> coprocessor), cvxif_resp_o (responses).
// Revision    : 1.0 - initial release
// ============================================================================
module cvxif_multi_slot_coprocessor
    import cvxif_pkg::*, cvxif_coproc_pkg::*;
#(
    parameter int unsigned NrSlots  = c_default_nr_slots,
    parameter int unsigned XLen     = c_default_xlen,
    parameter int unsigned LatMode  = c_default_lat_mode,
    parameter int unsigned FixedLat = c_default_fixed_lat,
    parameter int unsigned ResultRd = c_default_result_rd
)
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  cvxif_req_t  cvxif_req_i,
    output cvxif_resp_t cvxif_resp_o
);

    localparam int unsigned  c_ptr_w     = $clog2(NrSlots);
    localparam int unsigned  c_occ_w     = c_ptr_w + 1;
    localparam logic [3:0]   c_fixed_lat = 4'(FixedLat);
    localparam logic [4:0]   c_result_rd = 5'(ResultRd);

    logic [c_ptr_w-1:0] r_head_q, w_head_d;
    logic [c_ptr_w-1:0] r_tail_q, w_tail_d;
    logic [c_occ_w-1:0] r_occ_q,  w_occ_d;

    slot_t               w_slots [NrSlots];
    slot_t               w_head_slot;
    logic [NrSlots-1:0]  w_slot_write;
    logic [NrSlots-1:0]  w_slot_free;

    x_issue_resp_t       w_issue_resp;
    logic                w_issue_ready;
    logic                w_write;
    logic [XLen-1:0]     w_sum;
    logic [3:0]          w_lat;
    logic                w_res_valid;
    logic                w_head_free;
    logic                w_unused;

    assign w_issue_resp  = predecode(cvxif_req_i.x_issue_req.instr[6:0]);
    // Registered occupancy only: no combinational path from the issue inputs.
    assign w_issue_ready = (r_occ_q < c_occ_w'(NrSlots));
    assign w_write       = cvxif_req_i.x_issue_valid && w_issue_ready && w_issue_resp.accept;

    assign w_sum = cvxif_req_i.x_issue_req.rs[0][XLen-1:0]
                 + cvxif_req_i.x_issue_req.rs[1][XLen-1:0]
                 + cvxif_req_i.x_issue_req.rs[2][XLen-1:0];

    assign w_head_slot = w_slots[r_head_q];
    assign w_lat       = (LatMode == 1) ? c_fixed_lat : w_head_slot.sum[3:0];
    assign w_res_valid = (w_head_slot.state == SLOT_COMMITTED) && (w_head_slot.cnt >= w_lat);
    // A killed head drains without ever presenting a result.
    assign w_head_free = (w_res_valid && cvxif_req_i.x_result_ready)
                       || (w_head_slot.state == SLOT_KILLED);

    generate
        for (genvar i = 0; i < NrSlots; i++) begin : g_slots
            assign w_slot_write[i] = w_write     && (r_tail_q == c_ptr_w'(i));
            assign w_slot_free[i]  = w_head_free && (r_head_q == c_ptr_w'(i));

            cvxif_coproc_slot u_slot (
                .clk_i          (clk_i),
                .rst_i          (rst_i),
                .write_i        (w_slot_write[i]),
                .id_i           (cvxif_req_i.x_issue_req.id),
                .sum_i          (c_x_data_width'(w_sum)),
                .commit_valid_i (cvxif_req_i.x_commit_valid),
                .commit_id_i    (cvxif_req_i.x_commit.id),
                .commit_kill_i  (cvxif_req_i.x_commit.commit_kill),
                .free_i         (w_slot_free[i]),
                .slot_o         (w_slots[i])
            );
        end
    endgenerate

    always_comb begin
        w_tail_d = r_tail_q;
        w_head_d = r_head_q;
        w_occ_d  = r_occ_q;
        if (w_write) begin
            w_tail_d = r_tail_q + c_ptr_w'(1);
        end
        if (w_head_free) begin
            w_head_d = r_head_q + c_ptr_w'(1);
        end
        case ({w_write, w_head_free})
            2'b10:   w_occ_d = r_occ_q + c_occ_w'(1);
            2'b01:   w_occ_d = r_occ_q - c_occ_w'(1);
            default: w_occ_d = r_occ_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_head_q <= '0;
            r_tail_q <= '0;
            r_occ_q  <= '0;
        end else begin
            r_head_q <= w_head_d;
            r_tail_q <= w_tail_d;
            r_occ_q  <= w_occ_d;
        end
    end

    // Compressed and mem channels stay tied off (all-zero default).
    always_comb begin
        cvxif_resp_o                  = '0;
        cvxif_resp_o.x_issue_ready    = w_issue_ready;
        cvxif_resp_o.x_issue_resp     = w_issue_resp;
        cvxif_resp_o.x_result_valid   = w_res_valid;
        cvxif_resp_o.x_result.id      = w_head_slot.id;
        cvxif_resp_o.x_result.data    = w_head_slot.sum;
        cvxif_resp_o.x_result.rd      = c_result_rd;
    end

    assign w_unused = ^{cvxif_req_i.x_compressed_valid, cvxif_req_i.x_compressed_req,
                        cvxif_req_i.x_mem_ready, cvxif_req_i.x_issue_req.instr};

endmodule
`default_nettype wire

// File: tb/tb_cvxif_multi_slot_coprocessor.sv
`default_nettype none
// ============================================================================
// Module      : tb_cvxif_multi_slot_coprocessor
// Description : Directed self-checking bench. u_dut0 uses sum-based latency,
//               u_dut1 uses a fixed latency of 2. Expected results are queued
//               at issue time and popped when a result is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cvxif_multi_slot_coprocessor;
    import cvxif_pkg::*;

    typedef struct {
        logic [3:0]  id;
        logic [63:0] data;
    } exp_t;

    localparam logic [31:0] c_instr_op  = 32'h0000_007B;
    localparam logic [31:0] c_instr_bad = 32'h0000_0033;

    logic        clk = 1'b0;
    logic        rst;
    cvxif_req_t  req  [2];
    cvxif_resp_t resp [2];
    int          checks   = 0;
    int          failures = 0;
    exp_t        sb[$];
    int          n;

    always #5 clk = ~clk;

    cvxif_multi_slot_coprocessor #(
        .NrSlots(4), .XLen(64), .LatMode(0), .FixedLat(2), .ResultRd(17)
    ) u_dut0 (
        .clk_i        (clk),
        .rst_i        (rst),
        .cvxif_req_i  (req[0]),
        .cvxif_resp_o (resp[0])
    );

    cvxif_multi_slot_coprocessor #(
        .NrSlots(4), .XLen(64), .LatMode(1), .FixedLat(2), .ResultRd(17)
    ) u_dut1 (
        .clk_i        (clk),
        .rst_i        (rst),
        .cvxif_req_i  (req[1]),
        .cvxif_resp_o (resp[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int u, input logic [3:0] id,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        chk("issue_ready", 64'(resp[u].x_issue_ready), 64'd1);
        req[u].x_issue_valid       = 1'b1;
        req[u].x_issue_req.instr   = c_instr_op;
        req[u].x_issue_req.id      = id;
        req[u].x_issue_req.rs[0]   = a;
        req[u].x_issue_req.rs[1]   = b;
        req[u].x_issue_req.rs[2]   = c;
        #1;
        chk("issue_accept", 64'(resp[u].x_issue_resp.accept), 64'd1);
        tick();
        req[u].x_issue_valid = 1'b0;
    endtask

    task automatic commit(input int u, input logic [3:0] id, input logic kill);
        req[u].x_commit_valid       = 1'b1;
        req[u].x_commit.id          = id;
        req[u].x_commit.commit_kill = kill;
        tick();
        req[u].x_commit_valid = 1'b0;
    endtask

    task automatic wait_valid(input int u, input int budget, output int cycles);
        cycles = 0;
        while (!resp[u].x_result_valid && cycles < budget) begin
            tick();
            cycles++;
        end
        chk("result_valid_timeout", 64'(resp[u].x_result_valid), 64'd1);
    endtask

    task automatic check_head(input int u, input string tag);
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end else begin
            e.id   = 'x;
            e.data = 'x;
        end
        chk({tag, "_id"},      64'(resp[u].x_result.id),      64'(e.id));
        chk({tag, "_data"},    resp[u].x_result.data,         e.data);
        chk({tag, "_rd"},      64'(resp[u].x_result.rd),      64'd17);
        chk({tag, "_we_exc"},  64'({resp[u].x_result.we, resp[u].x_result.exc,
                                    resp[u].x_result.exccode}), 64'd0);
    endtask

    task automatic handshake(input int u);
        req[u].x_result_ready = 1'b1;
        tick();
        req[u].x_result_ready = 1'b0;
    endtask

    task automatic take(input int u, input string tag);
        check_head(u, tag);
        handshake(u);
    endtask

    initial begin
        req[0] = '0;
        req[1] = '0;
        rst    = 1'b1;
        tick();
        tick();
        chk("rst_result_valid", 64'(resp[0].x_result_valid), 64'd0);
        rst = 1'b0;
        chk("post_rst_issue_ready", 64'(resp[0].x_issue_ready), 64'd1);
        chk("tieoff_compressed", 64'({resp[0].x_compressed_ready, resp[0].x_compressed_resp}), 64'd0);
        chk("tieoff_mem", 64'({resp[0].x_mem_valid, resp[0].x_mem_req}), 64'd0);

        // Not-accepted instruction must leave state untouched.
        req[0].x_issue_valid     = 1'b1;
        req[0].x_issue_req.instr = c_instr_bad;
        req[0].x_issue_req.id    = 4'd7;
        #1;
        chk("reject_accept", 64'(resp[0].x_issue_resp.accept), 64'd0);
        tick();
        req[0].x_issue_valid = 1'b0;

        // Basic: id 3, sum 6, latency 6.
        issue(0, 4'd3, 64'd1, 64'd2, 64'd3);
        sb.push_back('{id: 4'd3, data: 64'd6});
        commit(0, 4'd3, 1'b0);
        wait_valid(0, 30, n);
        chk("t1_latency", 64'(n), 64'd6);
        take(0, "t1");

        // Stability while result_ready is low.
        issue(0, 4'd4, 64'd16, 64'd0, 64'd0);
        sb.push_back('{id: 4'd4, data: 64'd16});
        commit(0, 4'd4, 1'b0);
        chk("t2_valid_lat0", 64'(resp[0].x_result_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t2_hold_valid", 64'(resp[0].x_result_valid), 64'd1);
            chk("t2_hold_id",    64'(resp[0].x_result.id),    64'd4);
            chk("t2_hold_data",  resp[0].x_result.data,       64'd16);
        end
        take(0, "t2");

        // Out-of-order commits, in-order results.
        issue(0, 4'd1, 64'd1, 64'd0, 64'd0);
        issue(0, 4'd2, 64'd2, 64'd0, 64'd0);
        sb.push_back('{id: 4'd1, data: 64'd1});
        sb.push_back('{id: 4'd2, data: 64'd2});
        commit(0, 4'd2, 1'b0);
        commit(0, 4'd1, 1'b0);
        wait_valid(0, 30, n);
        take(0, "t3_first");
        wait_valid(0, 30, n);
        take(0, "t3_second");

        // Killed head produces no result.
        issue(0, 4'd1, 64'd5, 64'd0, 64'd0);
        issue(0, 4'd2, 64'd7, 64'd0, 64'd0);
        sb.push_back('{id: 4'd2, data: 64'd7});
        commit(0, 4'd1, 1'b1);
        chk("t4_killed_no_valid", 64'(resp[0].x_result_valid), 64'd0);
        commit(0, 4'd2, 1'b0);
        wait_valid(0, 30, n);
        take(0, "t4");

        // Full buffer and issue_ready recovery without bypass.
        for (int id = 8; id < 12; id++) begin
            issue(0, 4'(id), 64'(id), 64'd0, 64'd0);
            sb.push_back('{id: 4'(id), data: 64'(id)});
        end
        chk("t5_full_ready", 64'(resp[0].x_issue_ready), 64'd0);
        commit(0, 4'd8, 1'b0);
        wait_valid(0, 30, n);
        check_head(0, "t5_first");
        req[0].x_result_ready = 1'b1;
        chk("t5_ready_in_hs_cycle", 64'(resp[0].x_issue_ready), 64'd0);
        tick();
        req[0].x_result_ready = 1'b0;
        chk("t5_ready_after_hs", 64'(resp[0].x_issue_ready), 64'd1);
        commit(0, 4'd9, 1'b0);
        commit(0, 4'd10, 1'b0);
        commit(0, 4'd11, 1'b0);
        for (int k = 0; k < 3; k++) begin
            wait_valid(0, 30, n);
            take(0, "t5_drain");
        end

        // Reset with outstanding instructions.
        issue(0, 4'd12, 64'd0, 64'd0, 64'd0);
        issue(0, 4'd13, 64'd0, 64'd0, 64'd0);
        issue(0, 4'd14, 64'd0, 64'd0, 64'd0);
        commit(0, 4'd12, 1'b0);
        chk("t6_valid_before_rst", 64'(resp[0].x_result_valid), 64'd1);
        rst = 1'b1;
        tick();
        chk("t6_valid_in_rst", 64'(resp[0].x_result_valid), 64'd0);
        rst = 1'b0;
        chk("t6_ready_after_rst", 64'(resp[0].x_issue_ready), 64'd1);
        issue(0, 4'd5, 64'd1, 64'd1, 64'd1);
        sb.push_back('{id: 4'd5, data: 64'd3});
        commit(0, 4'd5, 1'b0);
        wait_valid(0, 30, n);
        chk("t6_latency", 64'(n), 64'd3);
        take(0, "t6");

        // Wrapping sum with fixed latency 2.
        issue(1, 4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        sb.push_back('{id: 4'd6, data: 64'd0});
        commit(1, 4'd6, 1'b0);
        wait_valid(1, 30, n);
        chk("t7_latency", 64'(n), 64'd2);
        take(1, "t7");

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/cvxif_multi_slot_coprocessor.md
CVXIF_MULTI_SLOT_COPROCESSOR -- requirements
Module: cvxif_multi_slot_coprocessor

Interface
REQ-001 Parameter NrSlots, default 4, meaning number of outstanding offloaded instructions; legal values are powers of two, 2..16.
REQ-002 Parameter XLen, default 64, meaning result datapath width in bits.
REQ-003 Parameter LatMode, default 0, meaning latency source: 0 is sum[3:0], 1 is the fixed value FixedLat.
REQ-004 Parameter FixedLat, default 2, meaning fixed commit-to-result latency in cycles when LatMode is 1, range 0..15.
REQ-005 Parameter ResultRd, default 17, meaning value driven on x_result.rd.
REQ-006 The block has one clock; reset is synchronous and active-high.
REQ-007 Port clk_i, input, width 1, meaning clock, rising edge.
REQ-008 Port rst_i, input, width 1, meaning synchronous active-high reset.
REQ-009 Port cvxif_req_i, input, type cvxif_req_t, meaning core-to-coprocessor compressed, issue, commit, mem and result-ready channels.
REQ-010 Port cvxif_resp_o, output, type cvxif_resp_t, meaning coprocessor-to-core responses.

Function
REQ-011 The compressed interface SHALL be tied off: ready = 0, accept = 0, instr = 0.
REQ-012 The mem interface SHALL be tied off: x_mem_valid = 0 and x_mem_req = 0.
REQ-013 Issue decode SHALL be combinational through the existing predecoder; x_issue_resp is a pure function of x_issue_req.
REQ-014 x_issue_ready SHALL equal (occupancy < NrSlots), computed from registered state only, with no path from the issue inputs.
REQ-015 On x_issue_valid && x_issue_ready && accept, the block SHALL write id and sum = rs[0]+rs[1]+rs[2] into the tail slot and advance the tail pointer by 1 modulo NrSlots.
REQ-016 The sum SHALL be computed modulo 2^XLen, with carries discarded.
REQ-017 A not-accepted handshake (accept = 0) SHALL leave all state unchanged.
REQ-018 Each slot SHALL have states FREE, ISSUED, COMMITTED and KILLED.
REQ-019 Slot transition FREE->ISSUED SHALL occur on a write.
REQ-020 Slot transition ISSUED->COMMITTED SHALL occur on commit_valid, a matching id and kill = 0; the slot latency counter clears to 0 on this transition.
REQ-021 Slot transition ISSUED->KILLED SHALL occur on commit_valid, a matching id and kill = 1.
REQ-022 The slot latency counter SHALL increment each cycle while COMMITTED and saturate at 15.
REQ-023 A commit whose id matches no ISSUED slot SHALL be ignored; the matching search covers all slots in parallel.
REQ-024 Results SHALL be returned in issue order from the head slot only.
REQ-025 x_result_valid SHALL be asserted when the head slot is COMMITTED and its counter is >= its latency (sum[3:0] or FixedLat).
REQ-026 When x_result_valid is asserted, x_result SHALL carry id = slot id, data = slot sum, rd = ResultRd, we = 0, exc = 0 and exccode = 0.
REQ-027 While x_result_valid && !x_result_ready, the valid signal and all x_result fields SHALL stay stable.
REQ-028 On x_result_valid && x_result_ready, the head slot SHALL become FREE and the head pointer SHALL advance by 1 at the next edge.
REQ-029 A KILLED head slot SHALL be freed one cycle later without asserting result_valid.
REQ-030 Issue-write, commit-update and head-free SHALL all take effect in the same cycle when they coincide.
REQ-031 The occupancy change SHALL be the write count minus the free count, range -1..+1.
REQ-032 When occupancy = NrSlots and the head frees in a cycle, x_issue_ready SHALL rise in the following cycle, with no same-cycle bypass.
REQ-033 Head and tail pointers SHALL wrap from NrSlots-1 to 0.
REQ-034 Full and empty SHALL be distinguished by the occupancy counter, of width $clog2(NrSlots)+1.
REQ-035 A commit and a write targeting the same slot in one cycle SHALL be impossible, because the commit only matches ISSUED slots.

Reset
REQ-036 While rst_i is sampled high, all slots SHALL be FREE and head = tail = occupancy = 0.
REQ-037 While rst_i is sampled high, x_result_valid SHALL be 0.
REQ-038 After reset, x_issue_ready SHALL be 1 in the first cycle following rst_i deassertion.
REQ-039 Reset mid-operation SHALL discard all outstanding instructions silently.

Structure
REQ-040 Slot state enum, slot struct (id, sum, state, cnt) and default parameter constants SHALL reside in cvxif_coproc_pkg.
REQ-041 The cvxif_req_t and cvxif_resp_t types SHALL remain in cvxif_pkg.
REQ-042 The block SHALL contain exactly one new sub-module, cvxif_coproc_slot, holding one slot register and its state machine, instantiated NrSlots times.

Verification
REQ-043 The bench SHALL cover: issue id 3, rs = {1, 2, 3}, commit kill = 0 -> result id 3, data 6, valid exactly 6 cycles after commit, rd 17.
REQ-044 The bench SHALL cover: 4 accepted issues with no commits -> issue_ready = 0; commit the first and accept its result -> issue_ready = 1 one cycle after the result handshake.
REQ-045 The bench SHALL cover: issue ids 1 and 2, commit 2 then 1 -> results in order id 1 then id 2.
REQ-046 The bench SHALL cover: kill id 1 (head), commit id 2 -> no result for 1; result for 2 appears once the head frees.
REQ-047 The bench SHALL cover: result_ready held low for 5 cycles -> valid, id and data stable for all 5 cycles.
REQ-048 The bench SHALL cover: rs = {2^64-1, 1, 0} with LatMode = 1 and FixedLat = 2 -> data 0, valid 2 cycles after commit.
REQ-049 The bench SHALL cover: rst_i asserted with 3 outstanding instructions -> next cycle result_valid = 0; after reset, issue_ready = 1 and a fresh issue id 5 returns normally.
